// File: rtl/adc_pkg.sv
// Shared constants, state encoding and width helper for the ADC
// sample path (averager and controller bench).
package adc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LOG2_N_DEF = 3;

    typedef enum logic {
        ACCUM = 1'b0,
        LAST  = 1'b1
    } avg_state_t;

    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/adc_minmax_tracker.sv
// Running window min/max with clear/update controls; final values
// fold in the current sample combinationally.
module adc_minmax_tracker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] final_min,
    output logic [DATA_W-1:0] final_max
);

    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;

    always_comb begin
        final_min = (sample < run_min) ? sample : run_min;
        final_max = (sample > run_max) ? sample : run_max;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_min <= '1;
            run_max <= '0;
        end else if (update) begin
            run_min <= final_min;
            run_max <= final_max;
        end
    end

endmodule

// File: rtl/adc_sample_averager.sv
// Windowed mean/min/max of ADC samples with a valid/ready result
// port, threshold alarm and sticky overrun flag.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] avg_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              alarm,
    output logic              overrun
);

    localparam int AW = acc_width(DATA_W, LOG2_N);
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [LOG2_N-1:0] CNT_PRE  = CNT_LAST - 1'b1;

    avg_state_t        state;
    avg_state_t        state_nxt;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [LOG2_N-1:0] count;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] fin_min;
    logic [DATA_W-1:0] fin_max;
    logic              acc_en;
    logic              load;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM: if (sample_valid && count == CNT_PRE) state_nxt = LAST;
            LAST:  if (sample_valid) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        acc_en = 1'b0;
        load   = 1'b0;
        unique case (state)
            ACCUM: acc_en = sample_valid;
            LAST:  load   = sample_valid;
            default: ;
        endcase
    end

    assign sum = acc + {{LOG2_N{1'b0}}, sample_in};
    assign avg = sum[AW-1:LOG2_N];

    always_ff @(posedge clk) begin
        if (rst || load) begin
            acc   <= '0;
            count <= '0;
        end else if (acc_en) begin
            acc   <= sum;
            count <= count + 1'b1;
        end
    end

    adc_minmax_tracker #(.DATA_W(DATA_W)) u_minmax (
        .clk       (clk),
        .rst       (rst),
        .clear     (load),
        .update    (acc_en),
        .sample    (sample_in),
        .final_min (fin_min),
        .final_max (fin_max)
    );

    // A load coinciding with acceptance retires the old result cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_out   <= '0;
            min_out   <= '0;
            max_out   <= '0;
            out_valid <= 1'b0;
            alarm     <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            avg_out   <= avg;
            min_out   <= fin_min;
            max_out   <= fin_max;
            out_valid <= 1'b1;
            alarm     <= (avg > threshold);
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager: directed windows plus
// randomized windows against a plain-arithmetic reference.
module tb_adc_sample_averager;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic [7:0] threshold = 8'hFF;
    logic [7:0] avg_out, min_out, max_out;
    logic       out_valid, out_ready, alarm, overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] win [8];

    adc_sample_averager dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .threshold    (threshold),
        .avg_out      (avg_out),
        .min_out      (min_out),
        .max_out      (max_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alarm        (alarm),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_avg();
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(win[i]);
        return 8'(s / 8);
    endfunction

    function automatic logic [7:0] ref_min();
        int m = 255;
        for (int i = 0; i < 8; i++) if (int'(win[i]) < m) m = int'(win[i]);
        return 8'(m);
    endfunction

    function automatic logic [7:0] ref_max();
        int m = 0;
        for (int i = 0; i < 8; i++) if (int'(win[i]) > m) m = int'(win[i]);
        return 8'(m);
    endfunction

    function automatic logic [26:0] observed();
        return {out_valid, avg_out, min_out, max_out, alarm, overrun};
    endfunction

    function automatic logic [26:0] expected_result(input logic ovr);
        logic [7:0] a;
        a = ref_avg();
        return {1'b1, a, ref_min(), ref_max(), (a > threshold), ovr};
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 8; i++) win[i] = v;
    endtask

    // Feeds win[]; returns at the negedge after the final capture edge.
    task automatic feed(input int gap_max, input logic ready_at_last);
        int g;
        for (int i = 0; i < 8; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                sample_valid = 1'b0;
            end
            @(negedge clk);
            sample_in = win[i];
            sample_valid = 1'b1;
            if (i == 7 && ready_at_last) out_ready = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        checks++;
        if (observed() !== 27'd0) begin
            errors++;
            $display("FAIL reset: got %h want %h", observed(), 27'd0);
        end
    endtask

    task automatic test_constant();
        logic [26:0] exp_v;
        threshold = 8'hFF;
        out_ready = 1'b1;
        fill(8'h10);
        feed(0, 1'b0);
        exp_v = expected_result(1'b0);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL const_result: got %h want %h", observed(), exp_v);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL const_one_cycle: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_ramp();
        logic [26:0] exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) win[i] = 8'(i);
        feed(0, 1'b0);
        exp_v = {1'b1, 8'h03, 8'h00, 8'h07, 1'b0, 1'b0};
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL ramp: got %h want %h", observed(), exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_full_scale();
        logic [26:0] exp_v;
        out_ready = 1'b1;
        fill(8'hFF);
        feed(1, 1'b0);
        exp_v = {1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL full_scale: got %h want %h", observed(), exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_alarm();
        out_ready = 1'b1;
        threshold = 8'h40;
        fill(8'h40);
        feed(0, 1'b0);
        checks++;
        if (alarm !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL alarm_equal: alarm/valid got %b%b want 01",
                     alarm, out_valid);
        end
        @(negedge clk);
        fill(8'h41);
        feed(0, 1'b0);
        checks++;
        if (alarm !== 1'b1 || avg_out !== 8'h41) begin
            errors++;
            $display("FAIL alarm_above: alarm/avg got %b %h want 1 41",
                     alarm, avg_out);
        end
        // alarm holds after acceptance
        @(negedge clk);
        checks++;
        if (alarm !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alarm_hold: alarm/valid got %b%b want 10",
                     alarm, out_valid);
        end
        threshold = 8'hFF;
    endtask

    task automatic test_overrun();
        logic [26:0] exp_v;
        out_ready = 1'b0;
        fill(8'h10);
        feed(0, 1'b0);
        exp_v = expected_result(1'b0);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL overrun_first: got %h want %h", observed(), exp_v);
        end
        fill(8'h20);
        feed(0, 1'b0);
        exp_v = expected_result(1'b1);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL overrun_second: got %h want %h", observed(), exp_v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: valid/overrun got %b%b want 01",
                     out_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] exp_v;
        do_reset();
        out_ready = 1'b0;
        fill(8'h30);
        feed(0, 1'b0);
        for (int i = 0; i < 8; i++) win[i] = 8'(8'h50 + i);
        feed(0, 1'b1);
        exp_v = expected_result(1'b0);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL accept_and_load: got %h want %h", observed(), exp_v);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL accept_and_load_drop: valid/overrun got %b%b want 00",
                     out_valid, overrun);
        end
    endtask

    task automatic test_reset_midwindow();
        logic [26:0] exp_v;
        int early;
        out_ready = 1'b1;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample_in = 8'hFF;
            sample_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        fill(8'h20);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) early++;
            sample_in = win[i];
            sample_valid = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL midreset_no_partial: early results %0d want 0", early);
        end
        exp_v = expected_result(1'b0);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL midreset_result: got %h want %h", observed(), exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [26:0] exp_v;
        out_ready = 1'b1;
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < 8; i++) win[i] = 8'($urandom_range(255, 0));
            threshold = 8'($urandom_range(255, 0));
            feed(2, 1'b0);
            exp_v = expected_result(1'b0);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL random_w%0d: got %h want %h", w, observed(), exp_v);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_drop_w%0d: out_valid got %b want 0",
                         w, out_valid);
            end
        end
    endtask

    initial begin
        out_ready = 1'b1;
        test_reset();
        test_constant();
        test_ramp();
        test_full_scale();
        test_alarm();
        test_overrun();
        test_back_to_back();
        test_reset_midwindow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Downstream consumer of the ADC controller's 8-bit conversion results. It accumulates a fixed window of 2^LOG2_N samples and produces the truncated mean, window minimum and window maximum. Results are presented on a valid/ready output port and compared against a runtime threshold to drive an alarm. It sits between the ADC controller's display/data register and the display or host logic.

## Interface

Parameters:
- DATA_W, 8: sample width.
- LOG2_N, 3: log2 of the window length; window = 8 samples at default; legal range 1..6.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  conversion result from the ADC controller.
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle.
- threshold  in  DATA_W  alarm level; sampled at window completion.
- avg_out  out  DATA_W  window mean, truncated.
- min_out  out  DATA_W  window minimum.
- max_out  out  DATA_W  window maximum.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- alarm  out  1  latched with each result: 1 when avg > threshold (strict).
- overrun  out  1  sticky: a result was overwritten before acceptance.

## Operation

- Reset values: avg_out=0, min_out=0, max_out=0, out_valid=0, alarm=0, overrun=0. Also on reset: accumulator=0, sample count=0, running min=all-ones, running max=0.
- Accumulator width is DATA_W+LOG2_N, so it cannot overflow. Default is 11 bits, max 2040.
- State machine, two states:
  - ACCUM: count < 2^LOG2_N−1. Each sample_valid adds sample_in to the accumulator, updates running min/max and increments count.
  - LAST: count = 2^LOG2_N−1. On sample_valid, the final values are formed using the current sample:
    - sum = acc + sample_in
    - avg = sum >> LOG2_N (truncation, no rounding)
    - min = min(running min, sample_in); max = max(running max, sample_in)
  - In the same cycle, LAST loads the results into the output registers, sets out_valid=1 and alarm=(avg>threshold). It then clears acc, sets count=0, running min=all-ones, running max=0, and returns to ACCUM.
- The block never stalls input. Every sample_valid is consumed regardless of out_ready.
- Output handshake:
  - out_valid stays high and the output registers stay stable until out_valid && out_ready. On that acceptance, out_valid drops next cycle.
  - If a new result loads while out_valid=1 and out_ready=0: the registers are overwritten with the new result, out_valid stays 1, and overrun sets. overrun clears only on rst.
  - If a new result loads in the same cycle as acceptance (out_valid && out_ready): the old result counts as accepted and the new one loads. out_valid stays 1 and overrun is not set.
- sample_valid while rst=1 is ignored.
- Reset mid-window discards the partial window. The next window starts fresh from the first sample_valid after rst deasserts.
- out_ready is ignored while out_valid=0.

## Timing

- Latency: results and out_valid are visible on the cycle after the clock edge that captured the final sample_valid.
- Back-to-back sample_valid on every cycle is supported. Minimum result spacing is 2^LOG2_N cycles.
- alarm changes only when a result loads (or on reset). It is held with the result.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `adc_pkg` holds:
  - default DATA_W and LOG2_N;
  - the state encoding (ACCUM, LAST);
  - the accumulator-width function DATA_W+LOG2_N, used by both this block and the ADC controller bench.
- One natural sub-module: `adc_minmax_tracker`. It holds the running min/max registers with clear and update inputs and exposes the combinational final-min/max values including the current sample.
- The top level holds the counter, accumulator, FSM and the output/handshake registers.

## Test plan

- Default parameters, 8 samples of 0x10, out_ready=1 → one cycle after the 8th: avg=0x10, min=0x10, max=0x10, out_valid=1 for exactly one cycle.
- Samples 0x00..0x07 → sum 28, avg=0x03 (truncated), min=0x00, max=0x07.
- 8 samples of 0xFF → avg=0xFF, min=max=0xFF. This also confirms the 11-bit accumulator holds 2040 without wrap.
- threshold=0x40: window of 0x40s → alarm=0; window of 0x41s → alarm=1.
- out_ready=0 across two full windows (0x10s then 0x20s) → second result overwrites (avg=0x20) and overrun=1 stays set. Then out_ready=1 → out_valid drops next cycle and overrun remains 1.
- 5 samples of 0xFF, then rst for 1 cycle, then 8 samples of 0x20 → avg=0x20, min=0x20, max=0x20. No result is ever produced for the partial window.
